// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_pkg / cbus_rr_arbiter
//
// Round-robin arbiter that merges NUM_INPUTS cache-bus masters (index 0 =
// I-side converter, index 1 = D-side converter) onto one memory-side port.
// A master owns the port for a whole transaction, burst beats included, and
// priority rotates past the owner when its transaction completes.
//
// Ports
//   clk     in   system clock, all state changes on posedge
//   resetn  in   synchronous active-low reset
//   ireqs   in   per-master requests  {valid,is_write,size,addr,strobe,data,len}
//   iresps  out  per-master responses {ready,last,data}
//   oreq    out  request to the memory/AXI side
//   oresp   in   response from the memory/AXI side
// -----------------------------------------------------------------------------
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;      // beats - 1
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp
);

    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg,   sel_next;
    logic [SEL_W-1:0]   prio_reg,  prio_next;

    // Candidate index for each scan position: (prio + gi) mod NUM_INPUTS.
    // The extra bit keeps the sum from overflowing before the wrap.
    logic [SEL_W-1:0]   cand_idx [NUM_INPUTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_cand
            logic [SEL_W:0] cand_sum;
            assign cand_sum = {1'b0, prio_reg} + (SEL_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum >= (SEL_W+1)'(NUM_INPUTS))
                                ? SEL_W'(cand_sum - (SEL_W+1)'(NUM_INPUTS))
                                : cand_sum[SEL_W-1:0];
        end
    endgenerate

    // First valid master in scan order. The loop runs from the far end so
    // that the nearest candidate to prio is the last (winning) assignment.
    logic               grant_found;
    logic [SEL_W-1:0]   grant_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (ireqs[cand_idx[k]].valid) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // Owner + 1, wrapped, becomes the next scan start.
    logic [SEL_W:0]     sel_inc;
    logic [SEL_W-1:0]   sel_after;

    assign sel_inc   = {1'b0, sel_reg} + (SEL_W+1)'(1);
    assign sel_after = (sel_inc >= (SEL_W+1)'(NUM_INPUTS)) ? '0 : sel_inc[SEL_W-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            prio_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            prio_reg  <= prio_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        prio_next  = prio_reg;
        unique case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    sel_next   = grant_idx;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Only the final handshake ends ownership; beat counting is
                // left to the master and the memory side.
                if (oresp.ready && oresp.last) begin
                    state_next = IDLE;
                    prio_next  = sel_after;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Routing is purely combinational from the registered owner, so the
    // request reaches memory the cycle after arbitration and drops to zero
    // in the same cycle the FSM returns to IDLE.
    assign oreq = (state_reg == BUSY) ? ireqs[sel_reg] : '0;

    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_resp
            assign iresps[gi] = (state_reg == BUSY && sel_reg == SEL_W'(gi)) ? oresp : '0;
        end
    endgenerate

    // The owner must keep its request up until the final handshake.
    valid_held: assert property (@(posedge clk) disable iff (!resetn)
                                 (state_reg == BUSY) |-> ireqs[sel_reg].valid);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int NI = 2;

    logic                   clk = 1'b0;
    logic                   resetn_drv;
    cbus_req_t  [NI-1:0]    ireqs_drv;
    cbus_resp_t [NI-1:0]    iresps_mon;
    cbus_req_t              oreq_mon;
    cbus_resp_t             oresp_drv;

    cbus_rr_arbiter #(.NUM_INPUTS(NI)) dut (
        .clk    (clk),
        .resetn (resetn_drv),
        .ireqs  (ireqs_drv),
        .iresps (iresps_mon),
        .oreq   (oreq_mon),
        .oresp  (oresp_drv)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port (-1 = nobody) and where the next
    // scan starts. Updated from the stimulus only.
    int  m_owner = -1;
    int  m_prio  = 0;
    int  m_beats = 0;
    int  m_done  = -1;
    bit  m_known = 1'b0;

    cbus_req_t req_a;   // I-side template
    cbus_req_t req_b;   // D-side template

    task automatic check_req(input string name, input cbus_req_t got, input cbus_req_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t oreq got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic check_rsp(input string name, input int idx, input cbus_resp_t got, input cbus_resp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t iresps[%0d] got=%h want=%h", name, $time, idx, got, want);
        end
    endtask

    // One clock: compare at negedge (model always, hand expectation when
    // exp_own >= 0: 0 = nobody owns, 1 = master 0, 2 = master 1), then
    // advance the model at posedge and return 1 time unit later.
    task automatic cycle(input string tag, input int exp_own);
        cbus_req_t  e_req;
        cbus_resp_t e_rsp;
        int         picked;
        @(negedge clk);
        if (m_known) begin
            e_req = (m_owner >= 0) ? ireqs_drv[m_owner] : '0;
            check_req({tag, "_model"}, oreq_mon, e_req);
            for (int i = 0; i < NI; i++) begin
                e_rsp = (m_owner == i) ? oresp_drv : '0;
                check_rsp({tag, "_model"}, i, iresps_mon[i], e_rsp);
            end
        end
        if (exp_own >= 0) begin
            e_req = (exp_own == 0) ? '0 : ireqs_drv[exp_own-1];
            check_req(tag, oreq_mon, e_req);
            for (int i = 0; i < NI; i++) begin
                e_rsp = (exp_own == i + 1) ? oresp_drv : '0;
                check_rsp(tag, i, iresps_mon[i], e_rsp);
            end
        end
        $display("cyc t=%0t %s rst_n=%0b v=%0b%0b rdy=%0b lst=%0b oreq.v=%0b owner=%0d",
                 $time, tag, resetn_drv, ireqs_drv[1].valid, ireqs_drv[0].valid,
                 oresp_drv.ready, oresp_drv.last, oreq_mon.valid, m_owner);
        @(posedge clk);
        m_done = -1;
        if (!resetn_drv) begin
            m_owner = -1;
            m_prio  = 0;
            m_beats = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_owner < 0) begin
                picked = -1;
                for (int k = 0; k < NI; k++)
                    if (picked < 0 && ireqs_drv[(m_prio + k) % NI].valid)
                        picked = (m_prio + k) % NI;
                m_owner = picked;
                m_beats = 0;
            end else if (oresp_drv.ready) begin
                if (oresp_drv.last) begin
                    m_done  = m_owner;
                    m_prio  = (m_owner + 1) % NI;
                    m_owner = -1;
                end else begin
                    m_beats++;
                end
            end
        end
        #1;
    endtask

    task automatic set_in(input logic rn, input logic v0, input logic v1, input logic rdy, input logic lst);
        resetn_drv         = rn;
        ireqs_drv[0]       = req_a;
        ireqs_drv[0].valid = v0;
        ireqs_drv[1]       = req_b;
        ireqs_drv[1].valid = v1;
        oresp_drv.ready    = rdy;
        oresp_drv.last     = lst;
        oresp_drv.data     = 32'hDEAD_BEEF;
    endtask

    typedef struct {
        logic rst_n;
        logic v0;
        logic v1;
        logic rdy;
        logic lst;
        int   own;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int beats;
        cbus_req_t r;

        req_a = '{valid: 1'b1, is_write: 1'b0, size: 3'd2, addr: 32'h1FC0_0000,
                  strobe: 4'h0, data: 32'h0, len: 4'd0};
        req_b = '{valid: 1'b1, is_write: 1'b1, size: 3'd2, addr: 32'h8000_1000,
                  strobe: 4'hF, data: 32'h1234_5678, len: 4'd0};

        // Reset, single I-side beat, ready pulses in IDLE, simultaneous
        // requests and the one-cycle bubble between grants.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("pre", -1);
        cycle("pre", -1);

        foreach (vecs[i]) begin
            set_in(vecs[i].rst_n, vecs[i].v0, vecs[i].v1, vecs[i].rdy, vecs[i].lst);
            cycle($sformatf("vec%0d", i), vecs[i].own);
        end

        // D-side 16-beat burst, ready every other cycle, I-side waiting.
        req_b.len = 4'd15;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t3_rst", -1);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("t3_idle", 0);
        beats = 0;
        for (int c = 0; c < 40 && beats < 16; c++) begin
            logic rdy;
            rdy = (c % 2 == 1);
            set_in(1'b1, 1'b1, 1'b1, rdy, rdy && (beats == 15));
            cycle("t3_burst", 2);
            if (rdy) beats++;
        end
        total++;
        if (beats != 16) begin
            bad++;
            $display("FAIL t3_beats got=%0d want=16", beats);
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("t3_bubble", 0);
        cycle("t3_i_grant", 1);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle("t3_i_done", 1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t3_end", 0);

        // Both masters always valid, single-beat transactions: 0,1,0,1,0,1.
        req_b.len = 4'd0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t4_rst", -1);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++)
            cycle("t4_order", (k % 2 == 0) ? 0 : ((k / 2) % 2) + 1);

        // Reset in beat 3 of an 8-beat D-side burst, with prio moved to 1.
        req_b.len = 4'd7;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t5_rst", -1);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("t5_idle", 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle("t5_i_beat", 1);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("t5_idle2", 0);
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("t5_beat1", 2);
        cycle("t5_beat2", 2);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("t5_beat3_rst", 2);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("t5_after_rst", 0);
        cycle("t5_grant0", 1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t5_end", -1);

        // Randomized traffic from well-behaved masters and memory.
        ireqs_drv = '0;
        for (int c = 0; c < 3000; c++) begin
            resetn_drv = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NI; i++) begin
                if (!ireqs_drv[i].valid && $urandom_range(0, 2) == 0) begin
                    r          = '0;
                    r.valid    = 1'b1;
                    r.is_write = 1'($urandom_range(0, 1));
                    r.size     = 3'($urandom_range(0, 2));
                    r.addr     = $urandom;
                    r.strobe   = 4'($urandom_range(0, 15));
                    r.data     = $urandom;
                    r.len      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                    ireqs_drv[i] = r;
                end
            end
            oresp_drv.ready = 1'($urandom_range(0, 1));
            if (m_owner >= 0)
                oresp_drv.last = oresp_drv.ready && (m_beats == int'(ireqs_drv[m_owner].len));
            else
                oresp_drv.last = 1'($urandom_range(0, 1));
            oresp_drv.data = $urandom;
            cycle("rnd", -1);
            if (m_done >= 0) ireqs_drv[m_done].valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
